// File: rtl/rsenc_lfsr.sv
// rsenc_lfsr: systematic RS(N, N-6) encoder over GF(2^8), p(x) = 0x187, g(x) roots alpha^1..alpha^6.
// Build macro RSENC_ERR_INJ_EN adds input inj_mask, XORed into every output-register load.
module rsenc_lfsr #(
    parameter int N = 255
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop
`ifdef RSENC_ERR_INJ_EN
    ,
    input  logic [7:0] inj_mask
`endif
);
    localparam int K = N - 6;
    localparam logic [7:0] CNT_LAST = 8'(N - 1);
    localparam logic [7:0] MSG_LAST = 8'(K - 1);

    localparam logic MSG = 1'b0;
    localparam logic PAR = 1'b1;

    // g(x) = x^6 + G5 x^5 + ... + G0
    localparam logic [7:0] G5 = 8'h7E;
    localparam logic [7:0] G4 = 8'hA0;
    localparam logic [7:0] G3 = 8'h22;
    localparam logic [7:0] G2 = 8'hA7;
    localparam logic [7:0] G1 = 8'hE4;
    localparam logic [7:0] G0 = 8'h5F;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
    endfunction

    // Constant c folds this into a fixed XOR network.
    function automatic logic [7:0] gf_scale(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    logic       state;
    logic [7:0] cnt;
    logic [7:0] r5, r4, r3, r2, r1, r0;
    logic       load_free;
    logic       in_fire;
    logic       par_load;
    logic       load;
    logic       cnt_last;
    logic [7:0] fb;
    logic [7:0] mask;
    logic [7:0] load_sym;

`ifdef RSENC_ERR_INJ_EN
    assign mask = inj_mask;
`else
    assign mask = 8'h00;
`endif

    assign load_free = ~out_valid | out_ready;
    assign in_ready  = (state == MSG) & load_free;
    assign in_fire   = in_valid & in_ready;
    assign par_load  = (state == PAR) & load_free;
    assign load      = in_fire | par_load;
    assign cnt_last  = (cnt == CNT_LAST);
    assign fb        = in_data ^ r5;
    // Injection touches only the output path; the LFSR sees clean in_data.
    assign load_sym  = (in_fire ? in_data : r5) ^ mask;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= MSG;
            cnt       <= 8'h00;
            r5        <= 8'h00;
            r4        <= 8'h00;
            r3        <= 8'h00;
            r2        <= 8'h00;
            r1        <= 8'h00;
            r0        <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            if (in_fire) begin
                r5 <= r4 ^ gf_scale(fb, G5);
                r4 <= r3 ^ gf_scale(fb, G4);
                r3 <= r2 ^ gf_scale(fb, G3);
                r2 <= r1 ^ gf_scale(fb, G2);
                r1 <= r0 ^ gf_scale(fb, G1);
                r0 <= gf_scale(fb, G0);
            end else if (par_load) begin
                // Six shifts leave r5..r0 cleared for the next codeword.
                r5 <= r4;
                r4 <= r3;
                r3 <= r2;
                r2 <= r1;
                r1 <= r0;
                r0 <= 8'h00;
            end

            if (load) begin
                out_data  <= load_sym;
                out_sop   <= (cnt == 8'h00);
                out_eop   <= par_load & cnt_last;
                out_valid <= 1'b1;
                cnt       <= cnt_last ? 8'h00 : cnt + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (in_fire && cnt == MSG_LAST) begin
                state <= PAR;
            end else if (par_load && cnt_last) begin
                state <= MSG;
            end
        end
    end

endmodule

// File: tb/tb_rsenc_lfsr.sv
// Scoreboard bench for rsenc_lfsr: stimulus queues expected symbols, a monitor pops on each output handshake
// and also checks decoder-side syndromes (Horner at alpha^1..alpha^6) at every codeword end.
module tb_rsenc_lfsr;
    localparam int N = 40;
    localparam int K = N - 6;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
`ifdef RSENC_ERR_INJ_EN
    logic [7:0] inj_mask = 8'h00;
`endif

    rsenc_lfsr #(.N(N)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop)
`ifdef RSENC_ERR_INJ_EN
        ,
        .inj_mask (inj_mask)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       known;
        logic       bad;
    } exp_t;

    exp_t       exp_q[$];
    int         nvec = 0;
    int         nfail = 0;
    logic       rdy_rand = 1'b0;
    logic       gap_en = 1'b0;
    logic [7:0] msg [K];
    logic [7:0] par [6];
    logic       par_known = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
    endfunction

    function automatic logic [7:0] mul_apow(input logic [7:0] a, input int e);
        logic [7:0] v;
        v = a;
        for (int i = 0; i < e; i++) v = xt(v);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, req);
        end
    endtask

    // out_ready driver: changes on the falling edge only
    initial begin
        forever begin
            @(negedge clk);
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor
    initial begin
        logic       held;
        logic [7:0] hd;
        logic       hs;
        logic       he;
        logic [7:0] syn [1:6];
        logic       any_nz;
        exp_t       e;
        held = 1'b0;
        hd = 8'h00;
        hs = 1'b0;
        he = 1'b0;
        for (int i = 1; i <= 6; i++) syn[i] = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (!clrn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_data", out_data, hd);
                    check("hold_flags", {5'd0, out_valid, out_sop, out_eop}, {5'd0, 1'b1, hs, he});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_output: got %02h, expected no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.known) check("data", out_data, e.data);
                        check("sop", {7'd0, out_sop}, {7'd0, e.sop});
                        check("eop", {7'd0, out_eop}, {7'd0, e.eop});
                        if (out_sop) for (int i = 1; i <= 6; i++) syn[i] = 8'h00;
                        for (int i = 1; i <= 6; i++) syn[i] = mul_apow(syn[i], i) ^ out_data;
                        if (e.eop) begin
                            if (!e.bad) begin
                                for (int i = 1; i <= 6; i++) check($sformatf("syndrome_%0d", i), syn[i], 8'h00);
                            end else begin
                                any_nz = 1'b0;
                                for (int i = 1; i <= 6; i++) if (syn[i] != 8'h00) any_nz = 1'b1;
                                nvec++;
                                if (!any_nz) begin
                                    nfail++;
                                    $display("FAIL inj_syndrome: got all-zero syndromes, expected nonzero");
                                end
                            end
                        end
                    end
                end
                held = out_valid & ~out_ready;
                hd = out_data;
                hs = out_sop;
                he = out_eop;
            end
        end
    end

    task automatic send_sym(input logic [7:0] d, input logic sop, input logic inj);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        #1;
        if (gap_en && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = d;
`ifdef RSENC_ERR_INJ_EN
        inj_mask = inj ? 8'h01 : 8'h00;
`endif
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
            in_valid = 1'b0;
            return;
        end
        e.data = d ^ {7'd0, inj};
        e.sop = sop;
        e.eop = 1'b0;
        e.known = 1'b1;
        e.bad = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef RSENC_ERR_INJ_EN
        inj_mask = 8'h00;
`endif
    endtask

    task automatic send_cw(input int inj_idx, input logic bad);
        exp_t e;
        for (int i = 0; i < K; i++) send_sym(msg[i], i == 0, i == inj_idx);
        for (int j = 0; j < 6; j++) begin
            e.data = par[j];
            e.sop = 1'b0;
            e.eop = (j == 5);
            e.known = par_known;
            e.bad = bad && (j == 5);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d entries pending, expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {7'd0, out_valid}, 8'h00);
        check({tag, "_out_data"}, out_data, 8'h00);
        check({tag, "_out_sop"}, {7'd0, out_sop}, 8'h00);
        check({tag, "_out_eop"}, {7'd0, out_eop}, 8'h00);
        check({tag, "_in_ready"}, {7'd0, in_ready}, 8'h01);
    endtask

    task automatic set_msg_zero();
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
    endtask

    task automatic set_msg_one();
        set_msg_zero();
        msg[K-1] = 8'h01;
        par = '{8'h7E, 8'hA0, 8'h22, 8'hA7, 8'hE4, 8'h5F};
        par_known = 1'b1;
    endtask

    task automatic set_msg_rand();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        par_known = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("in_reset");
        clrn = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("after_reset");

        // all-zero message: all-zero codeword, 6-cycle input stall
        set_msg_zero();
        par = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        par_known = 1'b1;
        send_cw(-1, 1'b0);
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!in_ready) stall++;
        end
        check("in_ready_low_cycles", 8'(stall), 8'd6);
        drain();

        // single 0x01 in the lowest message position: parity is g(x) itself
        set_msg_one();
        send_cw(-1, 1'b0);
        drain();

        // three back-to-back random codewords
        for (int c = 0; c < 3; c++) begin
            set_msg_rand();
            send_cw(-1, 1'b0);
        end
        drain();

        // random backpressure and input gaps
        rdy_rand = 1'b1;
        gap_en = 1'b1;
        set_msg_one();
        send_cw(-1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            set_msg_rand();
            send_cw(-1, 1'b0);
        end
        drain();
        rdy_rand = 1'b0;
        gap_en = 1'b0;
        repeat (2) @(negedge clk);

        // reset right after the 3rd parity symbol
        set_msg_rand();
        send_cw(-1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        #3;
        clrn = 1'b1;
        set_msg_one();
        send_cw(-1, 1'b0);
        drain();

`ifdef RSENC_ERR_INJ_EN
        // flip bit 0 of message symbol 5 on the output only
        set_msg_one();
        send_cw(5, 1'b1);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/rsenc_lfsr.md
# rsenc_lfsr

Systematic Reed-Solomon encoder over GF(2^8) (p(x) = x^8+x^7+x^2+x+1, 0x187), 6 parity symbols, generator g(x) = ∏(x+α^i) for i = 1..6. It is the transmit-side counterpart of `rsdec_syn` in the BER datapath:

- It accepts a stream of message symbols and emits each codeword as the message symbols passed through, followed by 6 parity symbols.
- Codewords are emitted highest degree first.
- Every emitted codeword yields all-zero syndromes at the decoder.

## Interface
Parameters:
- `N`, default 255: codeword length in symbols, range 7..255 (shortened codes allowed).
- `K`, localparam = N-6: message length in symbols.

Ports:
- `clk`, input, 1 bit: clock.
- `clrn`, input, 1 bit: reset, asynchronous, active-low.
- `in_valid`, input, 1 bit: `in_data` holds a message symbol.
- `in_ready`, output, 1 bit: the encoder accepts the symbol this cycle.
- `in_data`, input, 8 bits: message symbol, highest degree first.
- `out_valid`, output, 1 bit: `out_data` is valid.
- `out_ready`, input, 1 bit: the downstream block consumes the symbol this cycle.
- `out_data`, output, 8 bits: codeword symbol.
- `out_sop`, output, 1 bit: high with the first symbol of a codeword.
- `out_eop`, output, 1 bit: high with the last parity symbol (p0).
- `inj_mask`, input, 8 bits: present only when `RSENC_ERR_INJ_EN` is defined (see Configuration).

## Operation
Handshake definitions:
- Input handshake: `in_valid & in_ready`.
- Output handshake: `out_valid & out_ready`.

Parity state:
- Parity is held in registers r5..r0, each 8 bits. Constants g5..g0 are the coefficients of g(x) below x^6.
- Multiplication by a constant is fixed XOR logic, in the same form as the `rsdec_syn` scalers.

State machine:
- **MSG** (reset state)
  - `in_ready = ~out_valid | out_ready`.
  - On each input handshake: fb = `in_data` ^ r5; r5←r4^g5·fb; r4←r3^g4·fb; r3←r2^g3·fb; r2←r1^g2·fb; r1←r0^g1·fb; r0←g0·fb.
  - On each input handshake the output register loads `in_data`, and `out_valid` is set.
  - `out_sop` is set when the symbol counter is 0.
  - On the K-th input handshake the state goes to PAR.
- **PAR**
  - `in_ready` = 0.
  - When the output register is free (`~out_valid | out_ready`), it loads r5 and the registers shift: r5←r4 … r1←r0, r0←0.
  - The 6th parity load sets `out_eop`.
  - After the 6th parity load the state returns to MSG with r5..r0 = 0 and the counter = 0.
- Symbol counter: 0..N-1, increments on each output-register load, wraps to 0 after the N-th load.
- Output-register rules:
  - `out_data`, `out_sop` and `out_eop` hold stable while `out_valid & ~out_ready`.
  - `out_valid` clears on an output handshake with no new load in the same cycle.
- An `in_valid` that drops mid-message is legal: encoder state holds, bubbles appear on the output, and no symbol is lost.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `out_sop`=0, `out_eop`=0, `in_ready`=1, r5..r0=0, counter=0, state=MSG.
- Latency: a symbol accepted in cycle t is on `out_data` in cycle t+1.
- Parity: p5 is presented in the cycle after the last message symbol is loaded, provided `out_ready` was high.
- Throughput: with `in_valid` and `out_ready` held high, one symbol per cycle; codewords follow back to back with a 6-cycle input stall each (`in_ready` low during PAR).
- Simultaneous output handshake and new load: allowed; the register is replaced with no bubble.
- `out_ready` low during PAR: the shift freezes, and parity order and values are preserved.
- `clrn` asserted mid-codeword: all state returns to reset values immediately, the partial codeword is discarded, and the next input symbol starts a new codeword.

## Configuration
`RSENC_ERR_INJ_EN`:
- **Defined**:
  - Input `inj_mask[7:0]` exists.
  - On every output-register load, the loaded value is `symbol ^ inj_mask`.
  - Injection affects the output only; the LFSR always uses the clean `in_data`.
  - Used for BER error injection.
- **Undefined**: the port is absent and the output is never modified.

## Test plan
- Reset, then K symbols of 0x00 with `out_ready`=1 → N symbols of 0x00; `out_sop` on symbol 0; `out_eop` on symbol N-1; `in_ready` low for exactly 6 cycles.
- K-1 × 0x00 then 0x01 → message passes through unchanged; parity = g5,g4,g3,g2,g1,g0 in that order.
- 3 back-to-back random codewords (N=255 and N=40) fed into `rsdec_syn` → all six syndromes 0x00 at each codeword end.
- `out_ready` toggled pseudo-randomly at 50% and `in_valid` gapped → the output sequence is identical to the stall-free run, and no output changes while `out_valid & ~out_ready`.
- `clrn` pulsed after the 3rd parity symbol → outputs at reset values; the next codeword is correct, with `out_sop` on its first symbol.
- Macro defined, `inj_mask`=0x01 during one message symbol only → that output symbol has bit 0 flipped; parity matches the clean message; `rsdec_syn` reports nonzero syndromes.
